vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel divider, h/v counters, frame-buffer read port, registered RGB/sync.
// Latency: rd_en/addr combinational on the tick; sync/de/RGB appear one tick after the frame-buffer read.
// Backpressure: none; en=0 freezes all state; DONE freezes the raster permanently until reset.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FRAMES   = 1,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [23:0]       pix_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic              Hsync,
    output logic              Vsync,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              de,
    output logic [15:0]       frame_cnt,
    output logic              DONE
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0]  div_cnt;
    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] row_base;

    logic tick;
    logic h_last;
    logic v_last;
    logic frame_wrap;
    logic done_set;
    logic active;
    logic hs_win;
    logic vs_win;

    // Pixel already requested from the frame buffer, waiting for its data.
    logic pend_active;
    logic pend_hs_win;
    logic pend_vs_win;

    // Stage 0: tick, wrap detection, visibility and the read port.
    // The tick is also held off while rst_n is low so no read strobe escapes during reset.
    always_comb begin
        tick       = rst_n && en && !DONE && (int'(div_cnt) == CLK_DIV - 1);
        h_last     = (int'(h_cnt) == H_TOTAL - 1);
        v_last     = (int'(v_cnt) == V_TOTAL - 1);
        frame_wrap = tick && h_last && v_last;
        done_set   = frame_wrap && (FRAMES != 0) && (int'(frame_cnt) + 1 == FRAMES);
        active     = !DONE && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs_win     = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
        vs_win     = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
        rd_en      = active && tick;
        addr       = active ? (row_base + ADDR_W'(h_cnt)) : '0;
    end

    // Pixel-clock divider: free-runs 0..CLK_DIV-1 while enabled and not finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en && !DONE) begin
            div_cnt <= (int'(div_cnt) == CLK_DIV - 1) ? '0 : div_cnt + 1'b1;
        end
    end

    // Raster counters; row_base tracks v_cnt*H_ACTIVE incrementally so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt    <= v_cnt + 1'b1;
                    row_base <= row_base + ADDR_W'(H_ACTIVE);
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Completed-frame counter (saturating) and the sticky end-of-run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            DONE      <= 1'b0;
        end else begin
            if (frame_wrap && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (done_set) begin
                DONE <= 1'b1;
            end
        end
    end

    // Hold the position attributes of the pixel in flight until its data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_active <= 1'b0;
            pend_hs_win <= 1'b0;
            pend_vs_win <= 1'b0;
        end else if (tick) begin
            pend_active <= active;
            pend_hs_win <= hs_win;
            pend_vs_win <= vs_win;
        end
    end

    // Stage 1: register sync, de and colour together; the finishing tick loads the idle levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hsync     <= ~HS_POL;
            Vsync     <= ~VS_POL;
            de        <= 1'b0;
            {R, G, B} <= 24'h0;
        end else if (tick) begin
            Hsync     <= (pend_hs_win && !done_set) ? HS_POL : ~HS_POL;
            Vsync     <= (pend_vs_win && !done_set) ? VS_POL : ~VS_POL;
            de        <= pend_active && !done_set;
            {R, G, B} <= (pend_active && !done_set) ? pix_in : 24'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 8x6 raster, CLK_DIV=1 (FRAMES=2) and CLK_DIV=3 (free-running) instances.
// Expected outputs come from a position model: after t ticks the outputs describe raster position t-2.
// Frame buffers are registered models returning the requested address replicated on every channel.
`timescale 1ns/100ps
module tb_vga_timing_gen;

    localparam int AW = 4;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] fc;
        logic        dn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_a = 1'b0;
    logic          en_b = 1'b0;
    logic [23:0]   pix_a, pix_b;
    logic          rd_a, rd_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          hs_a, hs_b, vs_a, vs_b, de_a, de_b, done_a, done_b;
    logic [7:0]    r_a, g_a, b_a, r_b, g_b, b_b;
    logic [15:0]   fc_a, fc_b;

    int checks = 0;
    int passed = 0;
    int ec_a = 0;
    int ec_b = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .FRAMES(2), .ADDR_W(AW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .pix_in(pix_a), .rd_en(rd_a), .addr(addr_a),
        .Hsync(hs_a), .Vsync(vs_a), .R(r_a), .G(g_a), .B(b_a), .de(de_a),
        .frame_cnt(fc_a), .DONE(done_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b0), .FRAMES(0), .ADDR_W(AW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .pix_in(pix_b), .rd_en(rd_b), .addr(addr_b),
        .Hsync(hs_b), .Vsync(vs_b), .R(r_b), .G(g_b), .B(b_b), .de(de_b),
        .frame_cnt(fc_b), .DONE(done_b)
    );

    // Registered frame buffers: data for a read appears after the strobe's clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_a <= '0;
        else if (rd_a) pix_a <= {3{{4'h0, addr_a}}};
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_b <= '0;
        else if (rd_b) pix_b <= {3{{4'h0, addr_b}}};
    end

    // Registered outputs after t completed ticks (8x6 raster, sync at h 5..6 / v 4).
    function automatic exp_t expect_regs(int t, int frames);
        exp_t e;
        int p, h, v;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.fc = 16'((t / 48 > 65535) ? 65535 : t / 48);
        e.dn = (frames != 0) && (t >= frames * 48);
        if (!e.dn && t >= 2) begin
            p = t - 2;
            h = p % 8;
            v = (p / 8) % 6;
            e.hs = !(h >= 5 && h < 7);
            e.vs = !(v == 4);
            e.de = (h < 4) && (v < 3);
            e.r  = e.de ? 8'(v * 4 + h) : 8'd0;
            e.g  = e.r;
            e.b  = e.r;
        end
        return e;
    endfunction

    // Read port {rd_en, addr} while the raster sits at position t.
    function automatic logic [AW:0] expect_rd(int t, bit tick_now, bit dn);
        int h, v;
        bit act;
        h = t % 8;
        v = (t / 8) % 6;
        act = !dn && (h < 4) && (v < 3);
        return {act && tick_now, act ? AW'(v * 4 + h) : AW'(0)};
    endfunction

    task automatic test_reset();
        exp_t rv, o;
        rv = '0;
        rv.hs = 1'b1;
        rv.vs = 1'b1;
        rst_n = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        o = {hs_a, vs_a, de_a, r_a, g_a, b_a, fc_a, done_a};
        checks++;
        if (o !== rv) $display("FAIL reset_regs_a got %h want %h", o, rv); else passed++;
        o = {hs_b, vs_b, de_b, r_b, g_b, b_b, fc_b, done_b};
        checks++;
        if (o !== rv) $display("FAIL reset_regs_b got %h want %h", o, rv); else passed++;
        checks++;
        if ({rd_a, addr_a} !== 5'h0) $display("FAIL reset_rd_a got %h want 00", {rd_a, addr_a}); else passed++;
        checks++;
        if ({rd_b, addr_b} !== 5'h0) $display("FAIL reset_rd_b got %h want 00", {rd_b, addr_b}); else passed++;
        en_a = 1'b0;
        en_b = 1'b0;
        rst_n = 1'b1;
        ec_a = 0;
        ec_b = 0;
    endtask

    task automatic test_frame_timing();
        exp_t e, o;
        logic [AW:0] er;
        logic [7:0] rq[$];
        int first_hs = -1, hs_low = 0, vs_low = 0, done_rise = -1, frozen_ok = 0;
        logic [15:0] fc48 = '0, fc96 = '0;
        en_a = 1'b1;
        for (int k = 0; k <= 146; k++) begin
            #1;
            e = expect_regs(ec_a, 2);
            o = {hs_a, vs_a, de_a, r_a, g_a, b_a, fc_a, done_a};
            checks++;
            if (o !== e) $display("FAIL frame_regs k=%0d got %h want %h", k, o, e); else passed++;
            if (k >= 1 && k <= 48) begin
                if (!hs_a) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = k;
                end
                if (!vs_a) vs_low++;
                if (de_a) rq.push_back(r_a);
            end
            if (k == 48) fc48 = fc_a;
            if (k == 96) fc96 = fc_a;
            if (done_a && done_rise < 0) done_rise = k;
            if (k > 96 && done_a && !rd_a && hs_a && vs_a && !de_a) frozen_ok++;
            er = expect_rd(ec_a, en_a && ec_a < 96, ec_a >= 96);
            checks++;
            if ({rd_a, addr_a} !== er) $display("FAIL frame_rd k=%0d got %h want %h", k, {rd_a, addr_a}, er); else passed++;
            if (en_a && ec_a < 96) ec_a++;
            @(negedge clk);
        end
        checks++;
        if (first_hs !== 7) $display("FAIL hsync_first_edge got %0d want 7", first_hs); else passed++;
        checks++;
        if (hs_low !== 12) $display("FAIL hsync_low_cycles got %0d want 12", hs_low); else passed++;
        checks++;
        if (vs_low !== 8) $display("FAIL vsync_low_cycles got %0d want 8", vs_low); else passed++;
        checks++;
        if (rq.size() !== 12) $display("FAIL active_pixels got %0d want 12", rq.size()); else passed++;
        for (int i = 0; i < rq.size() && i < 12; i++) begin
            checks++;
            if (rq[i] !== 8'(i)) $display("FAIL pixel_seq i=%0d got %0d want %0d", i, rq[i], i); else passed++;
        end
        checks++;
        if (fc48 !== 16'd1) $display("FAIL frame_cnt_48 got %0d want 1", fc48); else passed++;
        checks++;
        if (fc96 !== 16'd2) $display("FAIL frame_cnt_96 got %0d want 2", fc96); else passed++;
        checks++;
        if (done_rise !== 96) $display("FAIL done_rise got %0d want 96", done_rise); else passed++;
        checks++;
        if (frozen_ok !== 50) $display("FAIL done_frozen got %0d want 50", frozen_ok); else passed++;
        en_a = 1'b0;
    endtask

    task automatic test_clkdiv_enable();
        exp_t e, o;
        logic [AW:0] er;
        for (int i = 0; i < 240; i++) begin
            #1;
            e = expect_regs(ec_b / 3, 0);
            o = {hs_b, vs_b, de_b, r_b, g_b, b_b, fc_b, done_b};
            checks++;
            if (o !== e) $display("FAIL div3_regs i=%0d got %h want %h", i, o, e); else passed++;
            if (i >= 25 && i < 30) en_b = 1'b0;
            else en_b = ($urandom_range(0, 3) != 0);
            #1;
            er = expect_rd(ec_b / 3, en_b && (ec_b % 3 == 2), 1'b0);
            checks++;
            if ({rd_b, addr_b} !== er) $display("FAIL div3_rd i=%0d got %h want %h", i, {rd_b, addr_b}, er); else passed++;
            if (en_b) ec_b++;
            @(negedge clk);
        end
        en_b = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e, o, rv;
        logic [AW:0] er;
        int done_rise = -1;
        rv = '0;
        rv.hs = 1'b1;
        rv.vs = 1'b1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        ec_a = 0;
        ec_b = 0;
        en_a = 1'b1;
        for (int k = 0; k <= 120; k++) begin
            #1;
            e = expect_regs(ec_a, 2);
            o = {hs_a, vs_a, de_a, r_a, g_a, b_a, fc_a, done_a};
            checks++;
            if (o !== e) $display("FAIL arst_regs k=%0d got %h want %h", k, o, e); else passed++;
            if (done_a && done_rise < 0) done_rise = k;
            if (k == 20) begin
                #0.5 rst_n = 1'b0;
                #0.5;
                o = {hs_a, vs_a, de_a, r_a, g_a, b_a, fc_a, done_a};
                checks++;
                if (o !== rv) $display("FAIL arst_clear_a got %h want %h", o, rv); else passed++;
                o = {hs_b, vs_b, de_b, r_b, g_b, b_b, fc_b, done_b};
                checks++;
                if (o !== rv) $display("FAIL arst_clear_b got %h want %h", o, rv); else passed++;
                checks++;
                if ({rd_a, addr_a} !== 5'h0) $display("FAIL arst_rd_a got %h want 00", {rd_a, addr_a}); else passed++;
                #0.5 rst_n = 1'b1;
                ec_a = 0;
                ec_b = 0;
                #0.5;
            end
            er = expect_rd(ec_a, en_a && ec_a < 96, ec_a >= 96);
            checks++;
            if ({rd_a, addr_a} !== er) $display("FAIL arst_rd k=%0d got %h want %h", k, {rd_a, addr_a}, er); else passed++;
            if (en_a && ec_a < 96) ec_a++;
            @(negedge clk);
        end
        checks++;
        if (done_rise !== 116) $display("FAIL arst_done_rise got %0d want 116", done_rise); else passed++;
        en_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_clkdiv_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
